simon_newer: RTL and testbench
==============================

Name: simon_newer

Overview:
- Iterative SIMON 32/64 block-cipher encryptor: 32-bit block as two 16-bit words, 64-bit key as four 16-bit words, 32 rounds.
- Computes one round per clock, with on-the-fly key expansion.
- Standalone crypto core; the host starts it with a start pulse and reads the result when done is asserted.

Parameters:
- None. Word size 16, key words 4, rounds 32 and the z0 sequence are fixed constants.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request encryption; sampled at the rising edge of clk.
- key  input  64  key {k3,k2,k1,k0}; k3 = key[63:48], k0 = key[15:0].
- plain_text  input  32  block {x,y}; x = [31:16], y = [15:0].
- cipher_text  output  32  registered result {x,y} after round 31.
- done  output  1  registered; high while cipher_text holds a valid result.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset effects: state IDLE, done=0, cipher_text=0, round counter 0, internal registers 0.
- Reset asserted mid-operation aborts the run immediately; it has priority over start.
- States and transitions:
  - IDLE: start=1 latches key and plain_text, sets counter=0, moves to RUN, done=0.
  - RUN: one round per cycle. When counter=31, the round output is written to cipher_text, done<=1 and the state moves to DONE. Otherwise counter increments.
  - DONE: done and cipher_text hold. start=1 behaves as in IDLE (latch inputs, done<=0, go to RUN).
- start while in RUN is ignored. A start held for several cycles therefore starts exactly one encryption.
- key and plain_text changes after the latch edge are ignored.
- Latency: start sampled at edge E0 gives done=1 and a valid cipher_text after edge E32 (32 cycles).
- done stays high until the next accepted start or reset.
- Round function, for round key k_i:
  - f(x) = (ROL1(x) & ROL8(x)) ^ ROL2(x).
  - x' = y ^ f(x) ^ k_i; y' = x.
  - All operations are 16-bit modular rotates and XORs.
- Key schedule (m=4):
  - Hold a 4-word window {k[i+3],k[i+2],k[i+1],k[i]}; round i uses k[i].
  - tmp = ROR3(k[i+3]) ^ k[i+1]; tmp = tmp ^ ROR1(tmp).
  - k[i+4] = k[i] ^ tmp ^ 16'hFFFC ^ z0[i]. z0[i] is XORed into bit 0 only.
  - Each round the window shifts down by one word and k[i+4] enters at the top.
- z0 sequence, bit index 0 first: 11111010001001010110000111001101111101000100101011000011100110. Only indices 0..27 are consumed.

Decomposition:
- Shared package simon_pkg:
  - constants WORD_W=16, KEY_WORDS=4, ROUNDS=32, Z0 (62-bit, index 0 = first bit above), C_CONST=16'hFFFC;
  - state enum {IDLE, RUN, DONE};
  - functions rol16/ror16.
- One sub-module is natural: simon_round. It is combinational and takes x, y and the key window, producing next x, next y and the next key word.
- The top level holds the FSM, counter and registers.

Test Plan:
- Reset: hold reset 2 cycles with start=1 -> done=0, cipher_text=0, no run starts.
- Standard vector: key=64'h1918111009080100, plain_text=32'h65656877, start held 2 cycles -> done rises exactly 32 cycles after the first start edge; cipher_text=32'hc69be9bb.
- Back-to-back runs: while in DONE, start with key=64'hae4f4b3f2bea21bb, plain_text=32'hb94dd41b -> done drops the cycle after start; later cipher_text=32'h8494f458 with done=1.
- Sequence of runs: key 09586108cdaade2c / pt 9d09da8b -> deb4c76b; key a1f6a78d5886c60a / pt 5be7b347 -> fc29a459; key ccc85d3d82b2d23a / pt e8e18044 -> 32294659.
- Input isolation: change key and plain_text and pulse start during RUN -> result unchanged (c69be9bb for the standard vector) and latency still 32.
- Mid-run reset: assert reset at round 10 -> done=0 and cipher_text=0 next cycle; a subsequent start yields the correct ciphertext.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants, FSM state type and 16-bit rotate helpers for the SIMON 32/64 core.
package simon_pkg;

    localparam int WORD_W    = 16;
    localparam int KEY_WORDS = 4;
    localparam int ROUNDS    = 32;

    // Declared [0:61] so Z0[0] is the first bit of the published z0 sequence.
    localparam logic [0:61] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    localparam logic [WORD_W-1:0] C_CONST = 16'hFFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] rol16(input logic [WORD_W-1:0] v, input int n);
        return (v << n) | (v >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] ror16(input logic [WORD_W-1:0] v, input int n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational SIMON 32/64 round plus the matching key-schedule step.
// Only k[i], k[i+1] and k[i+3] of the window are needed to form x', y' and k[i+4].
module simon_round
    import simon_pkg::*;
(
    input  logic [WORD_W-1:0] x_i,
    input  logic [WORD_W-1:0] y_i,
    input  logic [WORD_W-1:0] k0_i,
    input  logic [WORD_W-1:0] k1_i,
    input  logic [WORD_W-1:0] k3_i,
    input  logic              z_i,
    output logic [WORD_W-1:0] x_o,
    output logic [WORD_W-1:0] y_o,
    output logic [WORD_W-1:0] knew_o
);

    logic [WORD_W-1:0] f;
    logic [WORD_W-1:0] tmp;

    always_comb begin
        f      = (rol16(x_i, 1) & rol16(x_i, 8)) ^ rol16(x_i, 2);
        x_o    = y_i ^ f ^ k0_i;
        y_o    = x_i;
        tmp    = ror16(k3_i, 3) ^ k1_i;
        tmp    = tmp ^ ror16(tmp, 1);
        knew_o = k0_i ^ tmp ^ C_CONST ^ {{(WORD_W-1){1'b0}}, z_i};
    end

endmodule

// File: rtl/simon_newer.sv
// Iterative SIMON 32/64 encryptor: one round per clock, key expanded on the fly.
// start in IDLE/DONE latches key and block; done rises 32 edges later and holds until restart.
module simon_newer
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [31:0] plain_text,
    output logic [31:0] cipher_text,
    output logic        done
);

    localparam int KW = WORD_W * KEY_WORDS;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [KW-1:0]     kwin_q, kwin_d;
    logic [31:0]       ct_q, ct_d;
    logic              done_q, done_d;

    logic [WORD_W-1:0] x_nxt, y_nxt, k_new;

    simon_round u_round (
        .x_i    (x_q),
        .y_i    (y_q),
        .k0_i   (kwin_q[WORD_W-1:0]),
        .k1_i   (kwin_q[2*WORD_W-1:WORD_W]),
        .k3_i   (kwin_q[KW-1:3*WORD_W]),
        .z_i    (Z0[cnt_q]),
        .x_o    (x_nxt),
        .y_o    (y_nxt),
        .knew_o (k_new)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        kwin_d  = kwin_q;
        ct_d    = ct_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 5'd0;
                    x_d     = plain_text[31:16];
                    y_d     = plain_text[15:0];
                    kwin_d  = key;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                // start is deliberately ignored here so a held start runs once.
                x_d    = x_nxt;
                y_d    = y_nxt;
                kwin_d = {k_new, kwin_q[KW-1:WORD_W]};
                if (cnt_q == 5'(ROUNDS - 1)) begin
                    ct_d    = {x_nxt, y_nxt};
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            kwin_q  <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            kwin_q  <= kwin_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
        end
    end

    assign cipher_text = ct_q;
    assign done        = done_q;

endmodule

// File: tb/tb_simon_newer.sv
// Directed-vector bench for simon_newer using published SIMON 32/64 vectors.
module tb_simon_newer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] key;
    logic [31:0] plain_text;
    logic [31:0] cipher_text;
    logic        done;

    int checks   = 0;
    int failures = 0;

    simon_newer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .key         (key),
        .plain_text  (plain_text),
        .cipher_text (cipher_text),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one encryption (caller sits 1 time unit after an edge) and
    // measures latency from the first start edge to done.
    task automatic do_run(input string tag, input logic [63:0] k, input logic [31:0] pt,
                          input logic [31:0] exp_ct, input int hold, input bit disturb);
        int lat;
        key        = k;
        plain_text = pt;
        start      = 1'b1;
        tick();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            start = (i < hold) || (disturb && i == 5);
            if (disturb && i >= 3) begin
                key        = ~k;
                plain_text = ~pt;
            end
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd32);
        chk({tag, "_ct"}, cipher_text, exp_ct);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b1;
        key        = 64'h1918111009080100;
        plain_text = 32'h65656877;
        tick();
        tick();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ct", cipher_text, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (36) tick();
        chk("idle_no_run", 32'(done), 32'd0);

        do_run("std", 64'h1918111009080100, 32'h65656877, 32'hc69be9bb, 2, 1'b0);
        repeat (3) tick();
        chk("std_done_hold", 32'(done), 32'd1);
        chk("std_ct_hold", cipher_text, 32'hc69be9bb);

        do_run("b2b", 64'hae4f4b3f2bea21bb, 32'hb94dd41b, 32'h8494f458, 1, 1'b0);
        do_run("seq1", 64'h09586108cdaade2c, 32'h9d09da8b, 32'hdeb4c76b, 1, 1'b0);
        do_run("seq2", 64'ha1f6a78d5886c60a, 32'h5be7b347, 32'hfc29a459, 1, 1'b0);
        do_run("seq3", 64'hccc85d3d82b2d23a, 32'he8e18044, 32'h32294659, 1, 1'b0);
        do_run("iso", 64'h1918111009080100, 32'h65656877, 32'hc69be9bb, 1, 1'b1);

        // Abort partway through the schedule, then confirm a clean restart.
        key        = 64'h09586108cdaade2c;
        plain_text = 32'h9d09da8b;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ct", cipher_text, 32'd0);
        reset = 1'b0;
        repeat (40) tick();
        chk("midrst_idle", 32'(done), 32'd0);
        do_run("after_rst", 64'h1918111009080100, 32'h65656877, 32'hc69be9bb, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
